// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-like core: FSM states, opcodes,
// function codes and instruction field positions.
package mips_pkg;

  // Controller states; one instruction walks a subset of these in order.
  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    OpRtype = 4'd0,
    OpAddi  = 4'd1,
    OpLw    = 4'd2,
    OpSw    = 4'd3,
    OpBeq   = 4'd4,
    OpJ     = 4'd5
  } opcode_e;

  typedef enum logic [2:0] {
    FnAdd = 3'd0,
    FnSub = 3'd1,
    FnAnd = 3'd2,
    FnOr  = 3'd3,
    FnSlt = 3'd4
  } funct_e;

  localparam int unsigned NumRegs  = 8;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned InstrW   = 16;

  // Instruction field slice positions.
  localparam int unsigned OpHi  = 15;
  localparam int unsigned OpLo  = 12;
  localparam int unsigned RsHi  = 11;
  localparam int unsigned RsLo  = 9;
  localparam int unsigned RtHi  = 8;
  localparam int unsigned RtLo  = 6;
  localparam int unsigned RdHi  = 5;
  localparam int unsigned RdLo  = 3;
  localparam int unsigned FnHi  = 2;
  localparam int unsigned FnLo  = 0;
  localparam int unsigned ImmHi = 5;
  localparam int unsigned ImmLo = 0;
  localparam int unsigned JtHi  = 11;
  localparam int unsigned JtLo  = 0;

  // Only opcodes 0..5 are legal; any other opcode halts the core.
  function automatic logic op_legal(logic [3:0] op);
    return (op <= 4'd5);
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 8-entry register file: two combinational read ports, one synchronous write
// port; r0 always reads zero and writes to it are discarded.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [RegAddrW-1:0] raddr_a,
  input  logic [RegAddrW-1:0] raddr_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  input  logic                we,
  input  logic [RegAddrW-1:0] waddr,
  input  logic [DATA_W-1:0]   wdata
);

  logic [DATA_W-1:0] regs_q [NumRegs];

  // Register storage; writes to r0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '{default: '0};
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports with r0 forced to zero.
  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];
  end

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle 16-bit-ISA core: one ALU and one unified memory port, sequenced
// by a FETCH/DECODE/EXEC/MEM/WB controller with a ready-based memory handshake.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PC_W-1:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     target_q, target_d;
  logic [InstrW-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   aluout_q, aluout_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  // Low during reset and for the first edge after it, so the first fetch
  // request appears only after a clock edge has been seen out of reset.
  logic                run_q;

  opcode_e             op;
  funct_e              fn;
  logic [RegAddrW-1:0] rs, rt, rd;
  logic [DATA_W-1:0]   imm_ext;
  logic [PC_W-1:0]     imm_pc, jtarget;
  logic [DATA_W-1:0]   alu_b, alu_y;
  logic [DATA_W-1:0]   rf_rdata_a, rf_rdata_b, rf_wdata;
  logic                rf_we;
  logic [RegAddrW-1:0] rf_waddr;

  assign op      = opcode_e'(ir_q[OpHi:OpLo]);
  assign fn      = funct_e'(ir_q[FnHi:FnLo]);
  assign rs      = ir_q[RsHi:RsLo];
  assign rt      = ir_q[RtHi:RtLo];
  assign rd      = ir_q[RdHi:RdLo];
  assign imm_ext = {{(DATA_W - ImmHi - 1){ir_q[ImmHi]}}, ir_q[ImmHi:ImmLo]};
  assign imm_pc  = PC_W'({{PC_W{ir_q[ImmHi]}}, ir_q[ImmHi:ImmLo]});
  assign jtarget = PC_W'({{PC_W{1'b0}}, ir_q[JtHi:JtLo]});

  assign pc     = pc_q;
  assign halted = (state_q == StHalt);

  mips_regfile #(
    .DATA_W(DATA_W)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr_a(rs),
    .raddr_b(rt),
    .rdata_a(rf_rdata_a),
    .rdata_b(rf_rdata_b),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  // Shared ALU: R-type uses funct on A,B; everything else adds A + sext(imm).
  always_comb begin
    alu_b = (op == OpRtype) ? b_q : imm_ext;
    alu_y = a_q + alu_b;
    if (op == OpRtype) begin
      case (fn)
        FnSub:   alu_y = a_q - alu_b;
        FnAnd:   alu_y = a_q & alu_b;
        FnOr:    alu_y = a_q | alu_b;
        FnSlt:   alu_y = {{(DATA_W - 1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
        default: alu_y = a_q + alu_b;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      target_q <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      mdr_q    <= mdr_d;
      run_q    <= 1'b1;
    end
  end

  // Controller: next state, datapath updates and memory/retire outputs.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = '0;
    retire    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = aluout_q;

    unique case (state_q)
      StFetch: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_d    = mem_rdata[InstrW-1:0];
            pc_d    = pc_q + PC_W'(1);
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        a_d      = rf_rdata_a;
        b_d      = rf_rdata_b;
        // pc already points past this instruction.
        target_d = pc_q + imm_pc;
        state_d  = op_legal(ir_q[OpHi:OpLo]) ? StExec : StHalt;
      end
      StExec: begin
        case (op)
          OpRtype, OpAddi: begin
            aluout_d = alu_y;
            state_d  = StWb;
          end
          OpLw, OpSw: begin
            aluout_d = alu_y;
            state_d  = StMem;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = target_q;
            retire  = 1'b1;
            state_d = StFetch;
          end
          OpJ: begin
            pc_d    = jtarget;
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_addr = PC_W'(aluout_q);
        if (op == OpSw) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
        if (mem_ready) begin
          if (op == OpSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
        case (op)
          OpRtype: rf_waddr = rd;
          OpLw:    rf_wdata = mdr_q;
          default: ;
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench: bench-side memory with wait-state injection and an
// instruction-level reference model of the ISA.
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [7:0]  pc;
  logic        retire, halted;

  int n_checks = 0;
  int n_err = 0;

  // System memory as seen by the DUT, and the model's own copy.
  logic [15:0] mem   [256];
  logic [15:0] m_mem [256];
  logic [15:0] m_reg [8];
  logic [7:0]  m_pc;

  // Expectations produced by the model for the current instruction.
  int          e_cyc;
  bit          e_halt, e_st;
  logic [7:0]  e_addr;
  logic [15:0] e_data;

  always #5 clk = ~clk;

  mips_multicycle #(
    .DATA_W(16),
    .PC_W  (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .retire   (retire),
    .halted   (halted)
  );

  function automatic logic [15:0] enc_r(int rs, int rt, int rd, int fn);
    return {4'd0, 3'(rs), 3'(rt), 3'(rd), 3'(fn)};
  endfunction

  function automatic logic [15:0] enc_i(int op, int rs, int rt, int imm);
    return {4'(op), 3'(rs), 3'(rt), 6'(imm)};
  endfunction

  function automatic logic [15:0] enc_j(int t);
    return {4'd5, 12'(t)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'd0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
  endtask

  // Executes one instruction at ISA level and predicts its cycle count.
  task automatic model_exec(input int fw, input int mw);
    logic [15:0] ir, a, b, imm, v, sum;
    logic [3:0]  op;
    logic [7:0]  npc, addr;
    int          wr;
    ir   = m_mem[m_pc];
    op   = ir[15:12];
    a    = m_reg[ir[11:9]];
    b    = m_reg[ir[8:6]];
    imm  = {{10{ir[5]}}, ir[5:0]};
    npc  = m_pc + 8'd1;
    sum  = a + imm;
    addr = sum[7:0];
    v    = 16'd0;
    wr   = 0;
    e_st = 1'b0;
    e_halt = 1'b0;
    e_addr = 8'd0;
    e_data = 16'd0;
    case (op)
      4'd0: begin
        case (ir[2:0])
          3'd1: v = a - b;
          3'd2: v = a & b;
          3'd3: v = a | b;
          3'd4: v = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
          default: v = a + b;
        endcase
        wr = int'(ir[5:3]);
        e_cyc = 4 + fw;
      end
      4'd1: begin v = sum; wr = int'(ir[8:6]); e_cyc = 4 + fw; end
      4'd2: begin v = m_mem[addr]; wr = int'(ir[8:6]); e_cyc = 5 + fw + mw; end
      4'd3: begin
        m_mem[addr] = b;
        e_st = 1'b1; e_addr = addr; e_data = b;
        e_cyc = 4 + fw + mw;
      end
      4'd4: begin if (a == b) npc = npc + imm[7:0]; e_cyc = 3 + fw; end
      4'd5: begin npc = ir[7:0]; e_cyc = 3 + fw; end
      default: begin e_halt = 1'b1; e_cyc = 2 + fw; end
    endcase
    if (wr > 0) m_reg[wr] = v;
    m_pc = npc;
  endtask

  // Drives the memory port until retire or halt (bounded), inserting fw wait
  // cycles on the fetch and mw on the data access; checks request stability.
  task automatic run_one(input int fw, input int mw, output int cycles, output bit retired,
                         output bit wrote, output logic [7:0] waddr, output logic [15:0] wdata);
    int left, nreq;
    bit waiting;
    logic [25:0] held;
    cycles = 0; retired = 1'b0; wrote = 1'b0; waddr = '0; wdata = '0;
    left = 0; nreq = 0; waiting = 1'b0; held = '0;
    while (!retired && !halted && cycles < 40) begin
      if (mem_req) begin
        if (waiting) check("hold", {6'd0, mem_req, mem_we, mem_addr, mem_wdata}, {6'd0, held});
        else begin
          left = (nreq == 0) ? fw : mw;
          nreq++;
        end
        if (left > 0) begin
          left--;
          waiting = 1'b1;
          held = {mem_req, mem_we, mem_addr, mem_wdata};
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
        end else begin
          waiting = 1'b0;
          mem_ready = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wrote = 1'b1; waddr = mem_addr; wdata = mem_wdata;
          end
          mem_rdata = mem[mem_addr];
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      #1;
      if (retire) retired = 1'b1;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_step(input string name, input int fw, input int mw);
    int cyc;
    bit ret, wr;
    logic [7:0]  wa;
    logic [15:0] wd;
    model_exec(fw, mw);
    run_one(fw, mw, cyc, ret, wr, wa, wd);
    check({name, " cycles"}, cyc, e_cyc);
    check({name, " retire"}, ret, !e_halt);
    check({name, " halted"}, halted, e_halt);
    check({name, " pc"}, pc, m_pc);
    check({name, " store"}, wr, e_st);
    if (e_st) begin
      check({name, " st_addr"}, wa, e_addr);
      check({name, " st_data"}, wd, e_data);
    end
  endtask

  // Asserts reset at a falling edge, checks reset values, releases it and
  // checks the first fetch request.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rst mem_req", mem_req, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 8'd0);
    check("rst mem_wdata", mem_wdata, 16'd0);
    check("rst pc", pc, 8'd0);
    check("rst retire", retire, 1'b0);
    check("rst halted", halted, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("first mem_req", mem_req, 1'b1);
    check("first mem_addr", mem_addr, 8'd0);
    check("first pc", pc, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    #1;
    do_reset();

    // Directed program: ALU, memory, wait states, branch, jump, illegal op.
    mem[0]  = enc_i(1, 0, 1, 5);
    mem[1]  = enc_i(1, 0, 2, -3);
    mem[2]  = enc_r(1, 2, 3, 0);
    mem[3]  = enc_r(2, 1, 4, 4);
    mem[4]  = enc_i(3, 0, 3, -32);
    mem[5]  = enc_i(3, 0, 4, -31);
    mem[6]  = enc_i(1, 0, 0, 7);
    mem[7]  = enc_i(3, 0, 0, -30);
    mem[8]  = enc_i(2, 0, 1, -29);
    mem[9]  = enc_i(3, 0, 1, 2);
    mem[10] = enc_i(2, 0, 5, 2);
    mem[11] = enc_i(3, 0, 5, -28);
    mem[12] = enc_r(2, 1, 6, 1);
    mem[13] = enc_r(1, 2, 7, 2);
    mem[14] = enc_r(6, 7, 6, 3);
    mem[15] = enc_r(6, 1, 7, 7);
    mem[16] = enc_i(3, 0, 6, -27);
    mem[17] = enc_i(3, 0, 7, -26);
    mem[18] = enc_i(4, 1, 2, 5);
    mem[19] = enc_j(12'hFFF);
    mem[8'hE3] = 16'h1234;
    mem[8'hFF] = 16'hF000;
    m_mem = mem;
    for (int i = 0; i < 20; i++) run_step($sformatf("dir[%0d]", i), 0, (i == 10) ? 3 : 0);
    check("r3 sum", mem[8'hE0], 16'd2);
    check("r4 slt", mem[8'hE1], 16'd1);
    check("r0 zero", mem[8'hE2], 16'd0);
    check("sw addr2", mem[2], 16'h1234);
    check("lw r5", mem[8'hE4], 16'h1234);
    check("j target", pc, 8'hFF);

    run_step("illegal", 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("halt no req", mem_req, 1'b0);
      check("halt sticky", halted, 1'b1);
      @(posedge clk);
      @(negedge clk);
    end

    // Random ALU/memory/branch program with random wait states.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 4))
        0: mem[i] = enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                          $urandom_range(0, 7));
        1: mem[i] = enc_i(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 63));
        2: mem[i] = enc_i(2, 0, $urandom_range(0, 7), $urandom_range(32, 62));
        3: mem[i] = enc_i(3, 0, $urandom_range(0, 7), $urandom_range(32, 62));
        default: mem[i] = enc_i(4, $urandom_range(0, 7), $urandom_range(0, 7),
                                $urandom_range(0, 1));
      endcase
    end
    for (int i = 8'hE0; i < 8'hFF; i++) mem[i] = 16'($urandom);
    m_mem = mem;
    for (int i = 0; i < 40; i++) run_step("rnd", $urandom_range(0, 2), $urandom_range(0, 2));

    // Self-loop branch, then reset during a wait-stated fetch.
    do_reset();
    mem[0] = enc_i(1, 0, 1, 1);
    mem[1] = enc_i(4, 1, 1, -1);
    m_mem = mem;
    run_step("loop addi", 0, 0);
    run_step("loop beq0", 1, 0);
    run_step("loop beq1", 0, 0);
    check("loop pc", pc, 8'd1);

    check("abort req", mem_req, 1'b1);
    mem_ready = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("abort mem_req", mem_req, 1'b0);
    check("abort pc", pc, 8'd0);
    check("abort retire", retire, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("restart mem_req", mem_req, 1'b1);
    check("restart mem_addr", mem_addr, 8'd0);
    run_step("restart addi", 2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
